// File: rtl/ss_adc_ctrl_if.sv
// Counter and result port bundle for the single-slope ADC controller.
// master: controller side (drives counter controls and the result).
// slave:  counter and downstream consumer side.
// Ports:
//   ctr_count/ctr_overflow          counter state into the controller
//   ctr_en/ctr_set/ctr_setval       counter controls from the controller
//   data/sat/data_valid/data_ready  result valid/ready handshake
interface ss_adc_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] ctr_count;
  logic             ctr_overflow;
  logic             ctr_en;
  logic             ctr_set;
  logic [WIDTH-1:0] ctr_setval;
  logic [WIDTH-1:0] data;
  logic             sat;
  logic             data_valid;
  logic             data_ready;

  modport master (
    input  ctr_count, ctr_overflow, data_ready,
    output ctr_en, ctr_set, ctr_setval, data, sat, data_valid
  );

  modport slave (
    output ctr_count, ctr_overflow, data_ready,
    input  ctr_en, ctr_set, ctr_setval, data, sat, data_valid
  );
endinterface

// File: rtl/ss_adc_ctrl.sv
// Purpose: single-slope ADC conversion controller driving a ramp and an external counter.
// Latency: start -> SETTLE_CYCLES of load -> RUN until trip/overflow; result valid the cycle after RUN exit.
// Backpressure: result held in HOLD until data_ready; start is ignored while busy.
//
// Ports:
//   clk, rst      single clock, synchronous active-low reset
//   start         conversion request, honoured only in IDLE
//   cmp           asynchronous comparator (high when ramp >= input)
//   ramp_rst      ramp discharge switch control (1 = discharged)
//   busy          high whenever a conversion is in progress or pending hand-off
//   bus (master)  counter controls/status and the data/sat valid-ready result port
module ss_adc_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          cmp,
  output logic          ramp_rst,
  output logic          busy,
  ss_adc_ctrl_if.master bus
);

  // Settle counter only needs to reach SETTLE_CYCLES-1.
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_RUN,
    S_HOLD
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [SW-1:0]    settle_cnt;
  logic [SW-1:0]    settle_nxt;

  // Two-flop synchronizer for the asynchronous comparator.
  logic             cmp_meta;
  logic             cmp_s;

  // Result registers and their capture strobe.
  logic [WIDTH-1:0] data_q;
  logic             sat_q;
  logic             capture;
  logic [WIDTH-1:0] data_cap;
  logic             sat_cap;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      cmp_meta   <= 1'b0;
      cmp_s      <= 1'b0;
      data_q     <= '0;
      sat_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      cmp_meta   <= cmp;
      cmp_s      <= cmp_meta;
      if (capture) begin
        data_q <= data_cap;
        sat_q  <= sat_cap;
      end
    end
  end

  // Overflow outranks a simultaneous trip: the counter already wrapped, so
  // ctr_count no longer reflects the trip point and the result is saturated.
  always_comb begin
    sat_cap  = bus.ctr_overflow;
    data_cap = bus.ctr_overflow ? {WIDTH{1'b1}} : bus.ctr_count;
  end

  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    capture    = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt  = S_SETTLE;
          settle_nxt = '0;
        end
      end

      S_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_nxt = S_RUN;
        end else begin
          settle_nxt = settle_cnt + 1'b1;
        end
      end

      S_RUN: begin
        if (bus.ctr_overflow || cmp_s) begin
          state_nxt = S_HOLD;
          capture   = 1'b1;
        end
      end

      S_HOLD: begin
        // data_valid is implied by being in HOLD.
        if (bus.data_ready) begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Moore output decode.
  always_comb begin
    ramp_rst       = 1'b1;
    bus.ctr_set    = 1'b0;
    bus.ctr_en     = 1'b0;
    bus.data_valid = 1'b0;
    busy           = (state != S_IDLE);

    case (state)
      S_SETTLE: bus.ctr_set = 1'b1;
      S_RUN: begin
        ramp_rst   = 1'b0;
        bus.ctr_en = 1'b1;
      end
      S_HOLD:   bus.data_valid = 1'b1;
      default:  ;
    endcase
  end

  assign bus.ctr_setval = '0;
  assign bus.data       = data_q;
  assign bus.sat        = sat_q;

endmodule

// File: tb/tb_ss_adc_ctrl.sv
// Directed bench for ss_adc_ctrl with a behavioural model of the attached
// ramp counter (load has priority over increment; registered wrap flag).
module tb_ss_adc_ctrl;

  logic clk;
  logic rst;
  logic start;
  logic cmp;
  logic ramp_rst;
  logic busy;

  int n_checks = 0;
  int n_fail   = 0;

  ss_adc_ctrl_if #(.WIDTH(8)) bus ();

  ss_adc_ctrl #(.WIDTH(8), .SETTLE_CYCLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cmp      (cmp),
    .ramp_rst (ramp_rst),
    .busy     (busy),
    .bus      (bus)
  );

  // External counter model.
  logic [7:0] ctr_q = 8'd0;
  logic       ovf_q = 1'b0;
  logic       rdy   = 1'b0;

  always @(posedge clk) begin
    if (bus.ctr_set) begin
      ctr_q <= bus.ctr_setval;
      ovf_q <= 1'b0;
    end else if (bus.ctr_en) begin
      ctr_q <= ctr_q + 8'd1;
      ovf_q <= (ctr_q == 8'hFF);
    end else begin
      ovf_q <= 1'b0;
    end
  end

  assign bus.ctr_count    = ctr_q;
  assign bus.ctr_overflow = ovf_q;
  assign bus.data_ready   = rdy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_count(input int n, output bit ok);
    int cyc = 0;
    while (bus.ctr_count != 8'(n) && cyc < 400) begin
      @(negedge clk); cyc++;
    end
    ok = (bus.ctr_count == 8'(n));
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!bus.data_valid && cyc < 400) begin
      @(negedge clk); cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; cmp = 1'b0; rdy = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (ramp_rst !== 1'b1) begin n_fail++; $display("FAIL reset_ramp_rst: got %b want 1", ramp_rst); end
    n_checks++; if (bus.ctr_en !== 1'b0) begin n_fail++; $display("FAIL reset_ctr_en: got %b want 0", bus.ctr_en); end
    n_checks++; if (bus.ctr_set !== 1'b0) begin n_fail++; $display("FAIL reset_ctr_set: got %b want 0", bus.ctr_set); end
    n_checks++; if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid: got %b want 0", bus.data_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (bus.data !== 8'd0) begin n_fail++; $display("FAIL reset_data: got %0d want 0", bus.data); end
    n_checks++; if (bus.sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %b want 0", bus.sat); end
    n_checks++; if (bus.ctr_setval !== 8'd0) begin n_fail++; $display("FAIL reset_setval: got %0d want 0", bus.ctr_setval); end
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_stays_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_nominal();
    int n_set = 0;
    int cyc = 0;
    bit ok;
    rdy = 1'b1;
    pulse_start();
    while (!bus.ctr_en && cyc < 20) begin
      if (bus.ctr_set) n_set++;
      @(negedge clk); cyc++;
    end
    n_checks++; if (n_set != 4) begin n_fail++; $display("FAIL nom_set_cycles: got %0d want 4", n_set); end
    n_checks++; if (bus.ctr_count !== 8'd0) begin n_fail++; $display("FAIL nom_run_start_count: got %0d want 0", bus.ctr_count); end
    n_checks++; if (ramp_rst !== 1'b0) begin n_fail++; $display("FAIL nom_run_ramp_rst: got %b want 0", ramp_rst); end
    wait_count(100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL nom_reach_100: count got %0d want 100", bus.ctr_count); end
    cmp = 1'b1;
    wait_valid(cyc);
    n_checks++; if (cyc != 3) begin n_fail++; $display("FAIL nom_latency: got %0d want 3", cyc); end
    n_checks++; if (bus.data !== 8'd102) begin n_fail++; $display("FAIL nom_data: got %0d want 102", bus.data); end
    n_checks++; if (bus.sat !== 1'b0) begin n_fail++; $display("FAIL nom_sat: got %b want 0", bus.sat); end
    n_checks++; if (bus.ctr_en !== 1'b0 || ramp_rst !== 1'b1) begin n_fail++; $display("FAIL nom_hold_outputs: en %b ramp_rst %b want 0/1", bus.ctr_en, ramp_rst); end
    @(negedge clk);
    cmp = 1'b0;
    n_checks++; if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL nom_valid_one_cycle: got %b want 0", bus.data_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nom_idle_after: busy got %b want 0", busy); end
    n_checks++; if (bus.data !== 8'd102) begin n_fail++; $display("FAIL nom_data_held: got %0d want 102", bus.data); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_cmp_early();
    int n_en = 0;
    int cyc = 0;
    rdy = 1'b1; cmp = 1'b1;
    repeat (3) @(negedge clk);
    pulse_start();
    while (!bus.data_valid && cyc < 20) begin
      if (bus.ctr_en) n_en++;
      @(negedge clk); cyc++;
    end
    n_checks++; if (n_en != 1) begin n_fail++; $display("FAIL early_run_cycles: got %0d want 1", n_en); end
    n_checks++; if (bus.data !== 8'd0 || bus.sat !== 1'b0) begin n_fail++; $display("FAIL early_result: data %0d sat %b want 0/0", bus.data, bus.sat); end
    cmp = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_saturation();
    int n_en = 0;
    int cyc = 0;
    rdy = 1'b1; cmp = 1'b0;
    pulse_start();
    while (!bus.data_valid && cyc < 400) begin
      if (bus.ctr_en) n_en++;
      @(negedge clk); cyc++;
    end
    n_checks++; if (n_en != 257) begin n_fail++; $display("FAIL sat_run_cycles: got %0d want 257", n_en); end
    n_checks++; if (bus.data !== 8'd255) begin n_fail++; $display("FAIL sat_data: got %0d want 255", bus.data); end
    n_checks++; if (bus.sat !== 1'b1) begin n_fail++; $display("FAIL sat_flag: got %b want 1", bus.sat); end
    n_checks++; if (bus.ctr_en !== 1'b0) begin n_fail++; $display("FAIL sat_ctr_en: got %b want 0", bus.ctr_en); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_backpressure();
    int cyc;
    bit ok;
    rdy = 1'b0;
    pulse_start();
    wait_count(20, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_reach_20: count got %0d want 20", bus.ctr_count); end
    cmp = 1'b1;
    wait_valid(cyc);
    cmp = 1'b0;
    n_checks++; if (bus.data !== 8'd22) begin n_fail++; $display("FAIL bp_data: got %0d want 22", bus.data); end
    for (int i = 0; i < 10; i++) begin
      if (i == 3) start = 1'b1;
      if (i == 4) start = 1'b0;
      n_checks++;
      if (bus.data !== 8'd22 || bus.data_valid !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold_stable[%0d]: data %0d valid %b want 22/1", i, bus.data, bus.data_valid);
      end
      @(negedge clk);
    end
    rdy = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: busy %b valid %b want 0/0", busy, bus.data_valid); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || bus.ctr_set !== 1'b0) begin n_fail++; $display("FAIL bp_start_not_queued: busy %b set %b want 0/0", busy, bus.ctr_set); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_collision();
    int cyc;
    bit ok;
    rdy = 1'b1;
    pulse_start();
    wait_count(254, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL col_reach_254: count got %0d want 254", bus.ctr_count); end
    cmp = 1'b1;
    wait_valid(cyc);
    n_checks++; if (cyc != 3) begin n_fail++; $display("FAIL col_latency: got %0d want 3", cyc); end
    n_checks++; if (bus.sat !== 1'b1 || bus.data !== 8'd255) begin n_fail++; $display("FAIL col_result: data %0d sat %b want 255/1", bus.data, bus.sat); end
    cmp = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    bit ok;
    rdy = 1'b1;
    pulse_start();
    wait_count(50, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rmr_reach_50: count got %0d want 50", bus.ctr_count); end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_checks++; if (busy !== 1'b0 || bus.ctr_en !== 1'b0) begin n_fail++; $display("FAIL rmr_idle: busy %b en %b want 0/0", busy, bus.ctr_en); end
    n_checks++; if (ramp_rst !== 1'b1 || bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL rmr_outputs: ramp_rst %b valid %b want 1/0", ramp_rst, bus.data_valid); end
    n_checks++; if (bus.data !== 8'd0 || bus.sat !== 1'b0) begin n_fail++; $display("FAIL rmr_result_cleared: data %0d sat %b want 0/0", bus.data, bus.sat); end
    pulse_start();
    wait_count(10, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rmr_reach_10: count got %0d want 10", bus.ctr_count); end
    cmp = 1'b1;
    wait_valid(cyc);
    n_checks++; if (bus.data !== 8'd12 || bus.sat !== 1'b0) begin n_fail++; $display("FAIL rmr_reconvert: data %0d sat %b want 12/0", bus.data, bus.sat); end
    cmp = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_cmp_early();
    test_saturation();
    test_backpressure();
    test_collision();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ss_adc_ctrl.md
# ss_adc_ctrl

Single-slope ADC conversion controller: the consumer side of the ramp counter. On `start` it discharges the ramp and loads the counter with zero. It then releases the ramp and enables counting, and watches the (asynchronous) comparator. It captures the counter value when the comparator trips, or reports saturation on counter overflow. The result is presented on a valid/ready output port to downstream digital logic.

## Interface
- `WIDTH`, 8: counter and result width; must match the attached counter.
- `SETTLE_CYCLES`, 4: cycles the ramp is held discharged and the counter held in set before counting (≥1).
- `clk`  in  1  single clock.
- `rst`  in  1  reset, synchronous, active-low.
- `start`  in  1  conversion request; sampled only in IDLE.
- `cmp`  in  1  comparator output, asynchronous; high when ramp ≥ input.
- `ctr_count`  in  WIDTH  counter value.
- `ctr_overflow`  in  1  counter wrap flag; registered, high for the one cycle `ctr_count` shows 0 after a wrap from all-ones.
- `ctr_en`  out  1  counter increment enable.
- `ctr_set`  out  1  counter load strobe; takes priority over `ctr_en` in the counter.
- `ctr_setval`  out  WIDTH  counter load value; constant 0.
- `ramp_rst`  out  1  ramp discharge switch control.
- `busy`  out  1  high in every state except IDLE.
- `data`  out  WIDTH  conversion result.
- `sat`  out  1  result saturated (no comparator trip before overflow).
- `data_valid`  out  1  result available.
- `data_ready`  in  1  downstream accepts result.

## Operation
- `cmp` passes through a 2-flop synchronizer, giving `cmp_s`. Both flops reset to 0.
- States and transitions:
  - IDLE → SETTLE on `start`=1.
  - SETTLE holds for `SETTLE_CYCLES` cycles, counted by an internal counter, then → RUN.
  - RUN → HOLD on `ctr_overflow`=1 or `cmp_s`=1.
  - HOLD → IDLE when `data_valid`=1 and `data_ready`=1.
- Outputs are Moore-decoded from the state:
  - IDLE: `ramp_rst`=1, `ctr_set`=0, `ctr_en`=0.
  - SETTLE: `ramp_rst`=1, `ctr_set`=1, `ctr_en`=0.
  - RUN: `ramp_rst`=0, `ctr_set`=0, `ctr_en`=1.
  - HOLD: `ramp_rst`=1, `ctr_set`=0, `ctr_en`=0, `data_valid`=1.
- Capture on RUN exit:
  - Exit on `ctr_overflow`=1: `data` = all ones (255 at WIDTH=8), `sat`=1.
  - Exit on `cmp_s`=1 without overflow: `data` = `ctr_count`, `sat`=0.
  - `ctr_overflow` and `cmp_s` high in the same cycle: overflow wins, so `sat`=1.
- `data` and `sat` are registered and held stable through HOLD until the handshake.
  - They keep their last value after returning to IDLE.
- `start` outside IDLE is ignored; requests are not queued.
- `cmp_s` already high on the first RUN cycle captures 0 (`ctr_count`=0 after the SETTLE load).
- The result includes synchronizer latency with no compensation: a trip at count N reads N+2.

## Timing
- Reset values (any edge with `rst`=0, from any state): state IDLE, `ctr_en`=0, `ctr_set`=0, `ctr_setval`=0, `ramp_rst`=1, `busy`=0, `data`=0, `sat`=0, `data_valid`=0, synchronizer=0.
- Reset mid-conversion aborts immediately; no result is produced.
- `start` high at edge T: SETTLE occupies cycles T+1 … T+`SETTLE_CYCLES`, and RUN begins at T+`SETTLE_CYCLES`+1 with `ctr_count`=0.
- A `cmp` rise during the cycle `ctr_count`=N is seen as `cmp_s`=1 two edges later. At that edge `data` = N+2 and HOLD is entered; `data_valid` is high the next cycle.
- Without a trip, RUN lasts 2^WIDTH+1 cycles: `ctr_overflow` is seen on the cycle `ctr_count` wraps to 0.
- Minimum conversion-to-conversion spacing: 1 IDLE cycle after the handshake.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles with `start`=1 → `ramp_rst`=1, `ctr_en`=`ctr_set`=`data_valid`=`busy`=0, `data`=0; state stays IDLE.
- **Nominal conversion:** `start` pulse, raise `cmp` when `ctr_count`=100, `data_ready`=1.
  - `ctr_set` high for exactly 4 cycles; `data`=102, `sat`=0.
  - `data_valid` high for 1 cycle; IDLE next.
- **Saturation:** `start` with `cmp` held 0 → `ctr_en` high until `ctr_overflow`; then `data`=255, `sat`=1, `ctr_en`=0.
- **Backpressure:** complete a conversion with `data_ready`=0 for 10 cycles and `start` pulsed during HOLD.
  - `data` and `data_valid` stay stable for 10 cycles; the `start` is ignored.
  - Assert `data_ready`: return to IDLE with no new conversion.
- **Overflow/cmp collision:** time `cmp` so `cmp_s` rises in the same cycle as `ctr_overflow` → `sat`=1, `data`=255.
- **Reset mid-RUN:** drive `rst`=0 one cycle at `ctr_count`=50 → next cycle IDLE, `ctr_en`=0, `ramp_rst`=1, `data_valid`=0.
  - A following `start` converts normally.
